// File: rtl/instr_prefetch_queue_if.sv
// Handshake and program-memory bus between the prefetch queue, program memory,
// execute-stage redirect logic and the decode stage.
interface instr_prefetch_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 8,
    parameter int unsigned IW    = 16
);
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [OW-1:0] occupancy;

    modport slave (
        output imem_addr, instr_out, instr_pc, instr_valid, occupancy,
        input  imem_data, redirect, redirect_pc, instr_ready
    );

    modport master (
        input  imem_addr, instr_out, instr_pc, instr_valid, occupancy,
        output imem_data, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Fetch stage: walks the fetch PC through program memory, buffers {instr, pc}
// pairs in a circular FIFO and hands the head to decode; redirect flushes and refetches.
module instr_prefetch_queue #(
    parameter int unsigned    DEPTH    = 4,
    parameter int unsigned    AW       = 8,
    parameter int unsigned    IW       = 16,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_prefetch_queue_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          valid;
    logic          pop;
    logic          push;

    always_comb begin
        valid = (occ_q != '0);
        pop   = valid & bus.instr_ready;
        push  = ~bus.redirect & ((occ_q < OW'(DEPTH)) | pop);

        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        occ_d = occ_q;
        pc_d  = pc_q;

        if (bus.redirect) begin
            // A head popped in this cycle is still consumed; the flush drops everything else.
            rd_d  = '0;
            wr_d  = '0;
            occ_d = '0;
            pc_d  = bus.redirect_pc;
        end else begin
            if (push) begin
                mem_d[wr_q] = '{instr: bus.imem_data, pc: pc_q};
                wr_d        = wr_q + PW'(1);
                pc_d        = pc_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + OW'(1);
                2'b01:   occ_d = occ_q - OW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            occ_q <= '0;
            pc_q  <= RESET_PC;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            occ_q <= occ_d;
            pc_q  <= pc_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr_out   = mem_q[rd_q].instr;
    assign bus.instr_pc    = mem_q[rd_q].pc;
    assign bus.instr_valid = valid;
    assign bus.occupancy   = occ_q;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue: stimulus queues expected PCs,
// a negedge monitor checks every accepted head against them.
module tb_instr_prefetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    instr_prefetch_queue_if #(.DEPTH(4), .AW(8), .IW(16)) bus ();

    instr_prefetch_queue #(.DEPTH(4), .AW(8), .IW(16), .RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.imem_data = 16'hA000 + {8'h00, bus.imem_addr};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_range(input logic [7:0] first, input int n);
        logic [7:0] p;
        p = first;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(p);
            p = p + 8'd1;
        end
    endtask

    // Monitor: every accepted head must match the next expected PC.
    always @(negedge clk) begin
        if (!rst && bus.instr_valid && bus.instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %0h expected none", bus.instr_pc);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("head_pc", {24'h0, bus.instr_pc}, {24'h0, e});
                chk("head_instr", {16'h0, bus.instr_out}, {16'h0, 16'hA000 + {8'h00, e}});
            end
        end
    end

    initial begin
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("rst_out", {16'h0, bus.instr_out}, 32'h0);
        chk("rst_pc", {24'h0, bus.instr_pc}, 32'h0);
        chk("rst_occ", {29'h0, bus.occupancy}, 32'h0);
        chk("rst_addr", {24'h0, bus.imem_addr}, 32'h0);

        // S0: release reset, ready low; fill the queue
        rst = 1'b0;
        step();  // S1
        chk("first_valid", {31'h0, bus.instr_valid}, 32'h1);
        chk("first_pc", {24'h0, bus.instr_pc}, 32'h0);
        chk("first_instr", {16'h0, bus.instr_out}, 32'hA000);
        chk("first_occ", {29'h0, bus.occupancy}, 32'h1);
        repeat (9) step();  // S10
        chk("full_occ", {29'h0, bus.occupancy}, 32'h4);
        chk("full_addr", {24'h0, bus.imem_addr}, 32'h4);
        chk("full_head", {24'h0, bus.instr_pc}, 32'h0);

        // S11..S18: drain 0..7 while full
        step();
        expect_range(8'h00, 8);
        bus.instr_ready = 1'b1;
        repeat (8) step();  // S19
        bus.instr_ready = 1'b0;
        chk("s19_occ", {29'h0, bus.occupancy}, 32'h4);
        chk("s19_head", {24'h0, bus.instr_pc}, 32'h8);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h40;
        step();  // S20
        bus.redirect = 1'b0;
        chk("flush_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("flush_occ", {29'h0, bus.occupancy}, 32'h0);
        chk("flush_addr", {24'h0, bus.imem_addr}, 32'h40);
        step();  // S21
        chk("tgt_valid", {31'h0, bus.instr_valid}, 32'h1);
        chk("tgt_pc", {24'h0, bus.instr_pc}, 32'h40);
        chk("tgt_instr", {16'h0, bus.instr_out}, 32'hA040);
        expect_range(8'h40, 5);  // 44 is accepted in the redirect cycle
        bus.instr_ready = 1'b1;
        repeat (4) step();  // S25
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'hFE;
        step();  // S26
        bus.redirect = 1'b0;
        chk("wrap_gap", {31'h0, bus.instr_valid}, 32'h0);
        expect_range(8'hFE, 4);
        repeat (5) step();  // S31
        chk("wrap_drained", exp_q.size(), 32'h0);

        // Back-to-back redirects: 10 then 20
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h10;
        step();  // S32
        bus.redirect_pc = 8'h20;
        step();  // S33
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b1;
        chk("b2b_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("b2b_addr", {24'h0, bus.imem_addr}, 32'h20);
        expect_range(8'h20, 3);
        repeat (4) step();  // S37
        bus.instr_ready = 1'b0;
        repeat (2) step();  // S39
        chk("pre_rst_occ", {29'h0, bus.occupancy}, 32'h3);
        chk("pre_rst_head", {24'h0, bus.instr_pc}, 32'h23);

        // Asynchronous reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("arst_occ", {29'h0, bus.occupancy}, 32'h0);
        chk("arst_out", {16'h0, bus.instr_out}, 32'h0);
        chk("arst_pc", {24'h0, bus.instr_pc}, 32'h0);
        chk("arst_addr", {24'h0, bus.imem_addr}, 32'h0);
        repeat (2) step();  // S41
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        expect_range(8'h00, 3);
        repeat (4) step();  // S45
        bus.instr_ready = 1'b0;
        repeat (2) step();
        chk("final_drained", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
